// File: rtl/switch_pkg.sv
// Shared switch datapath constants: FIFO geometry, per-class default thresholds,
// FIFO_errors bit positions and the FIFO operating-mode encoding.
package switch_pkg;

  localparam int unsigned DATA_WIDTH    = 6;
  localparam int unsigned MF_ADDR_WIDTH = 2;
  localparam int unsigned VC_ADDR_WIDTH = 2;
  localparam int unsigned D_ADDR_WIDTH  = 2;

  localparam int unsigned MF_AF_DEFAULT = (2 ** MF_ADDR_WIDTH) - 1;
  localparam int unsigned MF_AE_DEFAULT = 1;
  localparam int unsigned VC_AF_DEFAULT = (2 ** VC_ADDR_WIDTH) - 1;
  localparam int unsigned VC_AE_DEFAULT = 1;
  localparam int unsigned D_AF_DEFAULT  = (2 ** D_ADDR_WIDTH) - 1;
  localparam int unsigned D_AE_DEFAULT  = 1;

  localparam int unsigned ERR_BIT_MF   = 0;
  localparam int unsigned ERR_BIT_VC0  = 1;
  localparam int unsigned ERR_BIT_VC1  = 2;
  localparam int unsigned ERR_BIT_D0   = 3;
  localparam int unsigned ERR_BIT_D1   = 4;
  localparam int unsigned ERR_BITS     = 5;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_INIT = 1'b1
  } fifo_mode_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register samples the pre-edge word, so a same-slot write on a full FIFO is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and an error flag.
// Define FIFO_UMBRAL_ERR_STICKY_EN to make fifo_error hold until reset or init.
module fifo_umbral
  import switch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_DEFAULT = (2 ** ADDR_WIDTH) - 1,
  parameter int unsigned AE_DEFAULT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] af_th,
  input  logic [ADDR_WIDTH-1:0] ae_th,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  fifo_mode_t            mode;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] af_th_q, ae_th_q;
  logic                  push_ok, pop_ok, reject;

  always_comb begin
    mode         = init ? MODE_INIT : MODE_RUN;
    empty        = (count == '0);
    full         = (count == FULL_COUNT);
    almost_full  = (count >= {1'b0, af_th_q});
    almost_empty = (count <= {1'b0, ae_th_q});
    // On full, a simultaneous pop frees the slot so the push is still accepted.
    push_ok      = (mode == MODE_RUN) && wr_en && (!full || rd_en);
    pop_ok       = (mode == MODE_RUN) && rd_en && !empty;
    reject       = (mode == MODE_RUN) && ((wr_en && !push_ok) || (rd_en && !pop_ok));
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out_valid <= 1'b0;
      fifo_error     <= 1'b0;
      af_th_q        <= ADDR_WIDTH'(AF_DEFAULT);
      ae_th_q        <= ADDR_WIDTH'(AE_DEFAULT);
    end else if (mode == MODE_INIT) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      data_out_valid <= 1'b0;
      fifo_error     <= 1'b0;
      af_th_q        <= af_th;
      ae_th_q        <= ae_th;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
      data_out_valid <= pop_ok;
`ifdef FIFO_UMBRAL_ERR_STICKY_EN
      fifo_error     <= fifo_error | reject;
`else
      fifo_error     <= reject;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_fifo_umbral;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [1:0] af_th = '0;
  logic [1:0] ae_th = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [5:0] data_in = '0;
  logic [5:0] data_out;
  logic       data_out_valid;
  logic [2:0] count;
  logic       empty, full, almost_full, almost_empty, fifo_error;

  fifo_umbral #(
    .DATA_WIDTH (6),
    .ADDR_WIDTH (2),
    .AF_DEFAULT (3),
    .AE_DEFAULT (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .af_th          (af_th),
    .ae_th          (ae_th),
    .wr_en          (wr_en),
    .data_in        (data_in),
    .rd_en          (rd_en),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .fifo_error     (fifo_error)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [5:0]  mq[$];
  int unsigned m_af, m_ae;
  logic [5:0]  m_dout;
  bit          m_dv, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",          32'(count),          32'(mq.size()));
    chk("empty",          32'(empty),          32'(mq.size() == 0));
    chk("full",           32'(full),           32'(mq.size() == DEPTH));
    chk("almost_full",    32'(almost_full),    32'(mq.size() >= m_af));
    chk("almost_empty",   32'(almost_empty),   32'(mq.size() <= m_ae));
    chk("fifo_error",     32'(fifo_error),     32'(m_err));
    chk("data_out_valid", 32'(data_out_valid), 32'(m_dv));
    chk("data_out",       32'(data_out),       32'(m_dout));
  endtask

  task automatic model_reset();
    mq.delete();
    m_af = 3; m_ae = 1; m_dout = '0; m_dv = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check.
  task automatic step(input bit w, input logic [5:0] d, input bit r,
                      input bit i, input logic [1:0] a, input logic [1:0] e);
    bit was_full, was_empty, pu, po, bad;
    wr_en = w; data_in = d; rd_en = r; init = i; af_th = a; ae_th = e;
    @(posedge clk);
    if (i) begin
      m_af = a; m_ae = e; mq.delete(); m_err = 0; m_dv = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      pu  = w && (!was_full || r);
      po  = r && !was_empty;
      bad = (w && !pu) || (r && !po);
      if (po) begin
        m_dout = mq.pop_front();
        m_dv = 1;
      end else begin
        m_dv = 0;
      end
      if (pu) mq.push_back(d);
`ifdef FIFO_UMBRAL_ERR_STICKY_EN
      m_err = m_err | bad;
`else
      m_err = bad;
`endif
    end
    #1;
    check_all();
  endtask

  task automatic push(input logic [5:0] d); step(1, d, 0, 0, 0, 0); endtask
  task automatic pop();                     step(0, '0, 1, 0, 0, 0); endtask
  task automatic idle();                    step(0, '0, 0, 0, 0, 0); endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Thresholds af=2, ae=1, then push three and pop three.
    step(0, '0, 0, 1, 2'd2, 2'd1);
    step(0, '0, 0, 1, 2'd2, 2'd1);
    push(6'h11); push(6'h22); push(6'h33);
    pop(); pop(); pop();
    idle();

    // Fill, then simultaneous push+pop on full.
    push(6'h01); push(6'h02); push(6'h03); push(6'h04);
    step(1, 6'h05, 1, 0, 0, 0);
    // Push while full.
    push(6'h06);
    idle(); idle();
    // Restore default thresholds (also clears a sticky error).
    step(0, '0, 0, 1, 2'd3, 2'd1);

    // Pop on empty with simultaneous push.
    step(1, 6'h3F, 1, 0, 0, 0);
    idle();
    pop();
    pop();
    idle();

    // Six push/pop pairs to wrap pointers, then mid-stream async reset.
    push(6'h2A);
    for (int k = 0; k < 6; k++) step(1, 6'(k + 8), 1, 0, 0, 0);
    push(6'h15);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    idle();

    // Random traffic with occasional re-initialisation.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 99) < 55), 6'($urandom), bit'($urandom_range(0, 99) < 50),
           bit'($urandom_range(0, 29) == 0), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
# fifo_umbral

Synchronous FIFO with programmable almost-full/almost-empty thresholds and a protocol-error flag. One instance per Main, VC and Destination FIFO of the switch datapath. Its `empty`, `almost_full`, `almost_empty` and `fifo_error` outputs are concatenated into the `FIFO_empties`/`FIFO_errors` buses of the flow-control state machine. Thresholds are captured while that state machine holds `init` high.

## Interface
- DATA_WIDTH, 6, width of a data word
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH
- AF_DEFAULT, DEPTH-1, almost-full threshold after reset
- AE_DEFAULT, 1, almost-empty threshold after reset

- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- init  in  1  reinitialise FIFO and capture thresholds
- af_th  in  ADDR_WIDTH  almost-full threshold, sampled while init=1
- ae_th  in  ADDR_WIDTH  almost-empty threshold, sampled while init=1
- wr_en  in  1  push request
- data_in  in  DATA_WIDTH  push data
- rd_en  in  1  pop request
- data_out  out  DATA_WIDTH  popped word, registered
- data_out_valid  out  1  data_out holds a word popped last cycle
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- almost_full  out  1  count >= af_th_q
- almost_empty  out  1  count <= ae_th_q
- fifo_error  out  1  push-on-full or pop-on-empty occurred

## Operation
- Reset values: pointers 0, count 0, data_out 0, data_out_valid 0, fifo_error 0, af_th_q=AF_DEFAULT, ae_th_q=AE_DEFAULT. Hence empty=1, full=0, almost_empty=1, almost_full=0.
- The block has two modes, RUN and INIT, selected directly by `init`. There is no internal state register beyond the stored data.
- INIT (init=1), every cycle:
  - af_th_q <= af_th and ae_th_q <= ae_th, so the last value before deassertion is kept.
  - Pointers, count and fifo_error are cleared.
  - data_out_valid <= 0.
  - wr_en and rd_en are ignored and not flagged.
  - Memory contents are left untouched.
- RUN push: accepted when wr_en=1 and full=0. Data is written at wr_ptr and wr_ptr increments modulo DEPTH, wrapping naturally.
- RUN pop: accepted when rd_en=1 and empty=0. data_out <= mem[rd_ptr], data_out_valid <= 1 and rd_ptr increments modulo DEPTH. On any cycle without an accepted pop, data_out_valid <= 0 and data_out holds its value.
- Simultaneous push and pop:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted. The pop frees the slot and no error is raised.
  - Empty: push accepted, pop rejected, error raised. Data is never bypassed.
- Count update: +1 for a push only, −1 for a pop only, 0 for both or neither. Arithmetic is unsigned ADDR_WIDTH+1 bits and never wraps.
- Error rules: fifo_error is set by a rejected push (full) or a rejected pop (empty). A rejected request does not change pointers, count or memory.
- Flags are combinational from registered count and thresholds.
- If af_th_q <= ae_th_q, both almost flags may be high together. This is legal and is not corrected.

## Timing
- Push at edge N: count, empty, full, almost_* reflect it after edge N, so they are visible in cycle N+1.
- Pop latency is 1 cycle: a request at edge N presents data_out and data_out_valid from edge N to N+1.
- fifo_error rises the cycle after the offending request edge.
- A new threshold takes effect on the almost flags the cycle after the init edge that samples it.
- Asserting reset mid-operation clears everything immediately and asynchronously. Release of reset is synchronous to clk by the integrating level.

## Configuration
- `FIFO_UMBRAL_ERR_STICKY_EN` defined: fifo_error is sticky. It stays 1 until reset or init, matching the latched error behaviour of the consumer state machine.
- Not defined: fifo_error is a one-cycle pulse per rejected request and is high on every cycle following a rejected request.

## Structure
- The shared package `switch_pkg` holds:
  - DATA_WIDTH, MF/VC/D ADDR_WIDTH constants;
  - default thresholds per FIFO class;
  - the error-bit index constants used to build FIFO_errors.
- One sub-module, `fifo_mem`:
  - DEPTH×DATA_WIDTH register array, one write port, one registered read port;
  - memory is not reset.
- Pointer, count, threshold and error logic live in `fifo_umbral`.

## Test plan
All scenarios use the defaults (DEPTH=4) unless stated.
- Reset then idle → count=0, empty=1, almost_empty=1, almost_full=0, data_out=0, fifo_error=0.
- init=1 for 2 cycles with af_th=2, ae_th=1, then push 0x11, 0x22, 0x33 → almost_full rises when count=2. Pop 3 times → data_out 0x11, 0x22, 0x33, each one cycle after rd_en.
- Fill to 4, then wr_en+rd_en together → count stays 4, full=1, fifo_error=0, output is the oldest word.
- Push while full → fifo_error=1 next cycle, count=4. With the macro it stays 1 until init; without it, it is a 1-cycle pulse.
- Pop while empty with a simultaneous push of 0x3F → count=1, fifo_error=1, data_out_valid=0. The next pop returns 0x3F.
- Six push/pop pairs to wrap the pointers, then assert reset mid-stream → all outputs at reset values in the same cycle.
